// File: rtl/frame_strobe_gen.sv
// frame_strobe_gen: column-level configuration stage driving the FrameStrobe
// bus into the south terminal tile. Accepts frame-write requests over a
// valid/ready handshake and, for requests addressed to this column, emits a
// registered one-hot strobe for StrobeCycles cycles followed by GapCycles idle
// cycles so row-bus frame data settles before the next latch.
//
// Ports:
//   UserCLK      clock, rising edge
//   Reset        synchronous active-high reset
//   ReqValid     request present
//   ReqReady     request can be accepted this cycle (IDLE and not in reset)
//   ColAddr      target column of the request
//   FrameAddr    frame index within the column
//   FrameStrobe  registered one-hot strobe to the terminal tile
//   Busy         high while strobing or in the settle gap
//   AddrErr      sticky out-of-range frame index flag for this column
//   ErrClr       clears AddrErr (a new error in the same cycle wins)
//   StrobeCount  strobes issued since reset, only with FRAME_STROBE_COUNT_EN
//
// Optional feature macro: FRAME_STROBE_COUNT_EN.
module frame_strobe_gen #(
  parameter int unsigned MaxFramesPerCol  = 20,
  parameter int unsigned FrameSelectWidth = 5,
  parameter int unsigned ColSelectWidth   = 5,
  parameter int unsigned ColumnId         = 0,
  parameter int unsigned StrobeCycles     = 2,
  parameter int unsigned GapCycles        = 1
) (
  input  logic                        UserCLK,
  input  logic                        Reset,
  input  logic                        ReqValid,
  output logic                        ReqReady,
  input  logic [ColSelectWidth-1:0]   ColAddr,
  input  logic [FrameSelectWidth-1:0] FrameAddr,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                        Busy,
  output logic                        AddrErr,
  input  logic                        ErrClr
`ifdef FRAME_STROBE_COUNT_EN
  ,
  output logic [15:0]                 StrobeCount
`endif
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeCycles - 1);
  localparam logic [CntW-1:0] GapLoad    = (GapCycles > 0) ? CntW'(GapCycles - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       err_q, err_d;
  logic                       accept;
  logic                       col_hit;
  logic                       in_range;
`ifdef FRAME_STROBE_COUNT_EN
  logic [15:0]                count_q, count_d;
`endif

  // Ready depends only on registered state and reset, never on ReqValid.
  assign ReqReady = (state_q == IDLE) && !Reset;
  assign accept   = ReqValid && ReqReady;
  assign col_hit  = (32'(ColAddr) == 32'(ColumnId));
  // Full-width unsigned compare: FrameAddr can encode more than MaxFramesPerCol.
  assign in_range = (32'(FrameAddr) < 32'(MaxFramesPerCol));

  assign FrameStrobe = strobe_q;
  assign Busy        = (state_q != IDLE);
  assign AddrErr     = err_q;
`ifdef FRAME_STROBE_COUNT_EN
  assign StrobeCount = count_q;
`endif

  // State and output registers; reset overrides everything including mid-strobe.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      strobe_q <= '0;
      err_q    <= 1'b0;
`ifdef FRAME_STROBE_COUNT_EN
      count_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
`ifdef FRAME_STROBE_COUNT_EN
      count_q  <= count_d;
`endif
    end
  end

  // Next-state, strobe pattern, counters and sticky error.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    err_d    = err_q;
`ifdef FRAME_STROBE_COUNT_EN
    count_d  = count_q;
`endif

    unique case (state_q)
      IDLE: begin
        strobe_d = '0;
        if (accept && col_hit && in_range) begin
          strobe_d = MaxFramesPerCol'(1) << FrameAddr;
          cnt_d    = StrobeLoad;
          state_d  = STROBE;
`ifdef FRAME_STROBE_COUNT_EN
          count_d  = count_q + 16'd1;
`endif
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          strobe_d = '0;
          if (GapCycles > 0) begin
            cnt_d   = GapLoad;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      GAP: begin
        strobe_d = '0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        strobe_d = '0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase

    // A new error outranks a clear in the same cycle.
    if (accept && col_hit && !in_range) begin
      err_d = 1'b1;
    end else if (ErrClr) begin
      err_d = 1'b0;
    end
  end

endmodule
